ddr_weight_rd_engine: RTL
=========================

Name: ddr_weight_rd_engine

Overview:
Upstream feeder of the weight FIFO controller. Takes a byte-length DDR read job (start address, length, conf pulse) and splits it into AXI4 read bursts. Pushes the returned 512-bit beats into an internal first-word-fall-through FIFO. Exposes that FIFO as the ddr_fifo_empty / ddr_fifo_req / ddr_fifo_data interface the weight controller consumes.

Parameters:
DDR_ADDR_LEN, 32, DDR byte-address width
SINGLE_LEN, 24, width of the byte-length field
DATA_LEN, 64, lane width; bus width is DATA_LEN*8 = 512 bits (64 bytes per beat)
MAX_BURST, 16, maximum beats per AXI burst (1..256)
FIFO_DEPTH, 64, beat FIFO depth; power of two, >= MAX_BURST
MAX_OUTSTANDING, 4, maximum AR bursts in flight

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ddr_conf  in  1  single-cycle job start pulse
ddr_st_addr  in  DDR_ADDR_LEN  job byte address; must be 64-byte aligned
ddr_len  in  SINGLE_LEN  job length in bytes
m_araddr  out  DDR_ADDR_LEN  AXI read address
m_arlen  out  8  AXI beats-1
m_arvalid  out  1  AXI address valid
m_arready  in  1  AXI address ready
m_rdata  in  DATA_LEN*8  AXI read data
m_rresp  in  2  AXI read response
m_rlast  in  1  AXI last beat
m_rvalid  in  1  AXI data valid
m_rready  out  1  AXI data ready
ddr_fifo_empty  out  1  FIFO empty
ddr_fifo_req  in  1  pop request
ddr_fifo_data  out  DATA_LEN*8  FIFO head, FWFT
idle  out  1  no job active, no outstanding bursts
done  out  1  one-cycle pulse when last beat of job is pushed

Behaviour:
- Reset (async assert, sync-deassert by system): m_arvalid=0, m_araddr=0, m_arlen=0, m_rready=0, ddr_fifo_empty=1, ddr_fifo_data=0, idle=1, done=0. FIFO pointers, counters and outstanding count are cleared. Reset mid-job drops the job; the AXI side is reset together with this block.
- Fixed AXI signals: ARSIZE=6 and ARBURST=INCR are implied constants and are not ports.
- Job latch: ddr_conf while idle=1 latches addr and beats = ceil(ddr_len/64) (ddr_len+63)>>6, SINGLE_LEN bits.
  - ddr_conf while busy is ignored.
  - ddr_len=0: no AR is issued; done pulses on the next cycle; idle stays 1.
  - Low 6 address bits are forced to zero.
- FSM states:
  - IDLE --conf, beats>0--> CALC.
  - CALC (1 cycle): burst = min(beats_left, MAX_BURST, (4096-addr[11:0])>>6). No burst crosses a 4 KB boundary. Go to ISSUE.
  - ISSUE: m_arvalid=1 only when outstanding<MAX_OUTSTANDING and fifo_free - reserved_beats >= burst (credit rule). AR fires on arvalid&&arready: addr+=burst*64, beats_left-=burst, reserved_beats+=burst, outstanding++. Then CALC if beats_left>0, else DRAIN.
  - DRAIN: wait until outstanding==0, then IDLE.
  - m_araddr/m_arlen are stable while arvalid=1 and unacknowledged.
- R channel: m_rready=1 whenever the job is active or outstanding>0 (the credit rule guarantees space). A beat pushes when rvalid&&rready. Each push does reserved_beats--. rlast does outstanding--. An AR handshake and an rlast in the same cycle net to zero.
- done: asserted the cycle after the final beat of the job is pushed. idle returns to 1 in that same cycle.
- FIFO:
  - FWFT: ddr_fifo_data is valid whenever ddr_fifo_empty=0.
  - Pop = ddr_fifo_req && !ddr_fifo_empty. Req while empty is ignored.
  - Simultaneous push and pop keep occupancy constant; push and pop on the same cycle at occupancy 1 is legal.
  - A push into a full FIFO cannot occur (credit rule); the bench asserts this.
  - Pointers wrap mod FIFO_DEPTH; one extra bit distinguishes full from empty.
- Idle output: idle=1 in IDLE with outstanding==0. The FIFO may still hold data while idle=1.

Optional Feature:
DDR_RD_RRESP_CHECK_EN:
- When defined: adds output rd_err (1 bit, reset 0). rd_err is set sticky on any accepted beat with m_rresp!=0 and cleared by the next ddr_conf. The offending data is still pushed.
- When undefined: no rd_err port; m_rresp is unused.

Test Plan:
- addr=0x1000, len=4608 (72 beats), arready=1, zero-latency memory -> AR bursts of 16,16,16,16,8 at 0x1000,0x1400,0x1800,0x1C00,0x2000. 72 beats popped in order. done pulses once.
- addr=0x0FC0, len=256 -> first burst arlen=0 at 0xFC0 (4 KB split), second arlen=2 at 0x1000.
- Consumer never pops, FIFO_DEPTH=64, len=8192 -> exactly 64 beats accepted. No further AR until pops occur. No overflow.
- len=0 conf -> no arvalid; done high 1 cycle later; idle stays 1.
- ddr_conf asserted mid-job with new addr -> ignored; the original job completes unchanged.
- Reset asserted mid-burst -> all outputs at reset values immediately (async). A new job after release runs from a clean state.
- With DDR_RD_RRESP_CHECK_EN: inject rresp=2 on beat 5 -> rd_err=1 until next conf; all beats still delivered.

Source files
------------

// File: rtl/ddr_weight_rd_engine.sv
// DDR weight read engine: splits a byte-length job into 4 KB-safe AXI4 read bursts
// and buffers returned beats in a FWFT FIFO. Optional DDR_RD_RRESP_CHECK_EN adds rd_err.
module ddr_weight_rd_engine #(
    parameter int DDR_ADDR_LEN    = 32,
    parameter int SINGLE_LEN      = 24,
    parameter int DATA_LEN        = 64,
    parameter int MAX_BURST       = 16,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ddr_conf,
    input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
    input  logic [SINGLE_LEN-1:0]   ddr_len,
    output logic [DDR_ADDR_LEN-1:0] m_araddr,
    output logic [7:0]              m_arlen,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_LEN*8-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic                    ddr_fifo_empty,
    input  logic                    ddr_fifo_req,
    output logic [DATA_LEN*8-1:0]   ddr_fifo_data,
    output logic                    idle,
    output logic                    done
`ifdef DDR_RD_RRESP_CHECK_EN
    ,
    output logic                    rd_err
`endif
);

    localparam int BUS_W  = DATA_LEN * 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CRED_W = (PTR_W + 2 > 10) ? PTR_W + 2 : 10;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]              state_reg;
    logic [DDR_ADDR_LEN-1:0] addr_reg;
    logic [SINGLE_LEN-1:0]   beats_left_reg;
    logic [SINGLE_LEN-1:0]   rx_left_reg;
    logic [8:0]              burst_reg;
    logic [OUT_W-1:0]        outstanding_reg;
    logic [OUT_W-1:0]        outstanding_next;
    logic [CRED_W-1:0]       reserved_reg;
    logic [CRED_W-1:0]       reserved_next;
    logic [PTR_W:0]          wr_ptr_reg;
    logic [PTR_W:0]          rd_ptr_reg;
    logic                    done_reg;
    logic                    arvalid_reg;
    logic [DDR_ADDR_LEN-1:0] araddr_reg;
    logic [7:0]              arlen_reg;
    logic [BUS_W-1:0]        mem [FIFO_DEPTH];

    logic                    idle_w;
    logic                    conf_accept;
    logic [SINGLE_LEN-1:0]   conf_beats;
    logic                    ar_fire;
    logic                    rready_w;
    logic                    push;
    logic                    rlast_fire;
    logic                    pop;
    logic                    fifo_empty;
    logic [PTR_W:0]          fifo_count;
    logic [CRED_W-1:0]       fifo_free;
    logic                    credit_ok;
    logic [6:0]              bound_beats;
    logic [8:0]              cap_w;
    logic [8:0]              burst_calc;
    logic                    last_burst;
    logic                    unused_addr_lsb;

    assign unused_addr_lsb = ^ddr_st_addr[5:0];

    assign idle_w      = (state_reg == ST_IDLE) && (outstanding_reg == '0);
    assign conf_accept = ddr_conf && idle_w;
    assign conf_beats  = SINGLE_LEN'(({1'b0, ddr_len} + (SINGLE_LEN + 1)'(63)) >> 6);

    assign ar_fire    = arvalid_reg && m_arready;
    assign rready_w   = (state_reg != ST_IDLE) || (outstanding_reg != '0);
    assign push       = m_rvalid && rready_w;
    assign rlast_fire = push && m_rlast;

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign pop        = ddr_fifo_req && !fifo_empty;
    assign fifo_free  = CRED_W'(FIFO_DEPTH) - CRED_W'(fifo_count);

    // Beats already promised to in-flight bursts are not free space yet.
    assign credit_ok = (outstanding_reg < OUT_W'(MAX_OUTSTANDING)) &&
                       ((fifo_free - reserved_reg) >= CRED_W'(burst_reg));

    // Beats remaining before the next 4 KB page boundary (1..64).
    assign bound_beats = 7'((13'd4096 - {1'b0, addr_reg[11:0]}) >> 6);

    always_comb begin
        cap_w = (int'(bound_beats) < MAX_BURST) ? 9'(bound_beats) : 9'(MAX_BURST);
        burst_calc = cap_w;
        if (beats_left_reg < SINGLE_LEN'(cap_w)) begin
            burst_calc = beats_left_reg[8:0];
        end
    end

    assign last_burst = (beats_left_reg == SINGLE_LEN'(burst_reg));

    always_comb begin
        reserved_next    = reserved_reg;
        outstanding_next = outstanding_reg;
        if (ar_fire) begin
            reserved_next    = reserved_next + CRED_W'(burst_reg);
            outstanding_next = outstanding_next + OUT_W'(1);
        end
        if (push) begin
            reserved_next = reserved_next - CRED_W'(1);
        end
        if (rlast_fire) begin
            outstanding_next = outstanding_next - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            beats_left_reg <= '0;
            burst_reg      <= '0;
            arvalid_reg    <= 1'b0;
            araddr_reg     <= '0;
            arlen_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (conf_accept && (conf_beats != '0)) begin
                        addr_reg       <= {ddr_st_addr[DDR_ADDR_LEN-1:6], 6'b0};
                        beats_left_reg <= conf_beats;
                        state_reg      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    burst_reg <= burst_calc;
                    state_reg <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // Address and length are frozen from the moment arvalid rises.
                    if (!arvalid_reg) begin
                        if (credit_ok) begin
                            arvalid_reg <= 1'b1;
                            araddr_reg  <= addr_reg;
                            arlen_reg   <= 8'(burst_reg - 9'd1);
                        end
                    end else if (m_arready) begin
                        arvalid_reg    <= 1'b0;
                        addr_reg       <= addr_reg + (DDR_ADDR_LEN'(burst_reg) << 6);
                        beats_left_reg <= beats_left_reg - SINGLE_LEN'(burst_reg);
                        state_reg      <= last_burst ? ST_DRAIN : ST_CALC;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding_next == '0) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_reg <= '0;
            reserved_reg    <= '0;
            rx_left_reg     <= '0;
            done_reg        <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;
            reserved_reg    <= reserved_next;
            done_reg        <= (conf_accept && (conf_beats == '0)) ||
                               (push && (rx_left_reg == SINGLE_LEN'(1)));
            if (conf_accept) begin
                rx_left_reg <= conf_beats;
            end else if (push && (rx_left_reg != '0)) begin
                rx_left_reg <= rx_left_reg - SINGLE_LEN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= m_rdata;
        end
    end

`ifdef DDR_RD_RRESP_CHECK_EN
    logic rd_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err_reg <= 1'b0;
        end else if (conf_accept) begin
            rd_err_reg <= 1'b0;
        end else if (push && (m_rresp != 2'b00)) begin
            rd_err_reg <= 1'b1;
        end
    end

    assign rd_err = rd_err_reg;
`else
    logic unused_rresp;
    assign unused_rresp = ^m_rresp;
`endif

    assign m_araddr       = araddr_reg;
    assign m_arlen        = arlen_reg;
    assign m_arvalid      = arvalid_reg;
    assign m_rready       = rready_w;
    assign ddr_fifo_empty = fifo_empty;
    assign ddr_fifo_data  = fifo_empty ? '0 : mem[rd_ptr_reg[PTR_W-1:0]];
    assign idle           = idle_w;
    assign done           = done_reg;

endmodule
